// File: rtl/instr_fetch_if.sv
// Instruction memory bus between the fetch unit (master) and the
// synchronous instruction ROM (slave).
interface instr_fetch_if #(
  parameter int unsigned PC_W    = 10,
  parameter int unsigned INSTR_W = 9
) ();

  logic [PC_W-1:0]    imem_addr;
  logic               imem_en;
  logic [INSTR_W-1:0] imem_data;

  modport master (
    output imem_addr,
    output imem_en,
    input  imem_data
  );

  modport slave (
    input  imem_addr,
    input  imem_en,
    output imem_data
  );

endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/issue unit: walks a PC over a synchronous instruction
// ROM, presents one instruction per cycle to Control, resolves bne
// redirects with a single bubble, honours stall and stops on halt.
module instr_fetch #(
  parameter int unsigned          PC_W     = 10,
  parameter int unsigned          INSTR_W  = 9,
  parameter int unsigned          OPC_W    = 4,
  parameter logic [OPC_W-1:0]     HALT_OPC = 4'b1111,
  parameter logic [OPC_W-1:0]     NOP_OPC  = 4'b1110
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic                Start,
  input  logic                Stall,
  input  logic                Branch,
  input  logic                CondFlag,
  instr_fetch_if.master       imem,
  output logic [INSTR_W-1:0]  instr,
  output logic [OPC_W-1:0]    opcode,
  output logic                instr_valid,
  output logic [PC_W-1:0]     pc_out,
  output logic                Busy,
  output logic                Done
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e            state_q,      state_d;
  logic [PC_W-1:0]   fetch_pc_q,   fetch_pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [PC_W-1:0]   pend_pc_q,    pend_pc_d;
  logic              busy_q,       busy_d;
  logic              done_q,       done_d;

  logic              imem_en_c;
  logic              halt_hit;
  logic              branch_taken;
  logic [4:0]        offset;
  logic [PC_W-1:0]   offset_sext;
  logic [PC_W-1:0]   branch_target;

  assign offset = imem.imem_data[4:0];

  // Offset sign-extended (or truncated) to PC width; target wraps mod 2^PC_W.
  if (PC_W >= 5) begin : g_sext_wide
    assign offset_sext = {{(PC_W-5){offset[4]}}, offset};
  end else begin : g_sext_narrow
    assign offset_sext = offset[PC_W-1:0];
  end

  assign branch_target = pend_pc_q + offset_sext;

  assign halt_hit     = pend_valid_q &&
                        (imem.imem_data[INSTR_W-1 -: OPC_W] == HALT_OPC);
  assign branch_taken = pend_valid_q && Branch && CondFlag;

  // Next-state logic: fetch sequencing, redirects, halt and start handling.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    imem_en_c    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d      = ST_RUN;
          fetch_pc_d   = '0;
          pend_valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (!Stall) begin
          if (halt_hit) begin
            // Halt wins over a branch presented in the same cycle.
            state_d      = ST_DONE;
            pend_valid_d = 1'b0;
          end else begin
            imem_en_c    = 1'b1;
            pend_valid_d = 1'b1;
            pend_pc_d    = fetch_pc_q;
            fetch_pc_d   = fetch_pc_q + PC_W'(1);
            if (branch_taken) begin
              // The word fetched this cycle is the fall-through; drop it.
              fetch_pc_d   = branch_target;
              pend_valid_d = 1'b0;
            end
          end
        end
      end
      default: begin
        state_d      = ST_IDLE;
        pend_valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and pipeline registers, cleared asynchronously.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign imem.imem_addr = fetch_pc_q;
  assign imem.imem_en   = imem_en_c;

  assign instr       = imem.imem_data;
  assign opcode      = pend_valid_q ? imem.imem_data[INSTR_W-1 -: OPC_W] : NOP_OPC;
  assign instr_valid = pend_valid_q;
  assign pc_out      = pend_pc_q;
  assign Busy        = busy_q;
  assign Done        = done_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a default-width unit (PC_W=10) for the sequencing,
// branch, stall and reset cases and a PC_W=4 unit for wrap-around.
module tb_instr_fetch;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_MOV  = 4'b0001;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_SW   = 4'b0011;
  localparam logic [3:0] OP_BNE  = 4'b0101;
  localparam logic [3:0] OP_NOP  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  typedef struct {
    logic       en;
    int         addr;
    logic       vld;
    int         pc;
    logic       busy;
    logic       done;
    logic [8:0] ins;
    logic [3:0] opc;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset_n;
  logic Start10, Start4, Stall, CondFlag;
  logic Branch10, Branch4;

  logic [8:0] rom10 [0:1023];
  logic [8:0] rom4  [0:15];

  logic [8:0] instr10, instr4;
  logic [3:0] opcode10, opcode4;
  logic       vld10, vld4;
  logic [9:0] pc10;
  logic [3:0] pc4;
  logic       busy10, busy4, done10, done4;

  exp_t q10 [$];
  exp_t q4  [$];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  instr_fetch_if #(.PC_W(10), .INSTR_W(9)) bus10 ();
  instr_fetch_if #(.PC_W(4),  .INSTR_W(9)) bus4  ();

  instr_fetch #(.PC_W(10)) dut10 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start10), .Stall(Stall),
    .Branch(Branch10), .CondFlag(CondFlag), .imem(bus10.master),
    .instr(instr10), .opcode(opcode10), .instr_valid(vld10),
    .pc_out(pc10), .Busy(busy10), .Done(done10)
  );

  instr_fetch #(.PC_W(4)) dut4 (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start4), .Stall(Stall),
    .Branch(Branch4), .CondFlag(CondFlag), .imem(bus4.master),
    .instr(instr4), .opcode(opcode4), .instr_valid(vld4),
    .pc_out(pc4), .Busy(busy4), .Done(done4)
  );

  // Control decode stand-in: Branch for bne.
  assign Branch10 = (opcode10 == OP_BNE);
  assign Branch4  = (opcode4  == OP_BNE);

  // Synchronous ROMs, output held while not enabled.
  always @(posedge Clk) begin
    if (bus10.imem_en) bus10.imem_data <= rom10[bus10.imem_addr];
    if (bus4.imem_en)  bus4.imem_data  <= rom4[bus4.imem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic en, input int addr, input logic vld, input int pc,
                              input logic busy, input logic done, input logic [8:0] word);
    exp_t e;
    e.en = en; e.addr = addr; e.vld = vld; e.pc = pc;
    e.busy = busy; e.done = done; e.ins = word;
    e.opc = vld ? word[8:5] : OP_NOP;
    return e;
  endfunction

  task automatic e10(input logic en, input int addr, input logic vld, input int pc,
                     input logic busy, input logic done);
    q10.push_back(mk(en, addr, vld, pc, busy, done, rom10[pc]));
  endtask

  task automatic e4(input logic en, input int addr, input logic vld, input int pc,
                    input logic busy, input logic done);
    q4.push_back(mk(en, addr, vld, pc, busy, done, rom4[pc % 16]));
  endtask

  // Scoreboard for the PC_W=10 unit, sampled mid-cycle.
  always @(negedge Clk) begin
    if (q10.size() > 0) begin
      exp_t e;
      e = q10.pop_front();
      check("u10 imem_en", {31'b0, bus10.imem_en}, {31'b0, e.en});
      if (e.en) check("u10 imem_addr", {22'b0, bus10.imem_addr}, e.addr);
      check("u10 instr_valid", {31'b0, vld10}, {31'b0, e.vld});
      if (e.vld) begin
        check("u10 pc_out", {22'b0, pc10}, e.pc);
        check("u10 instr", {23'b0, instr10}, {23'b0, e.ins});
      end
      check("u10 opcode", {28'b0, opcode10}, {28'b0, e.opc});
      check("u10 Busy", {31'b0, busy10}, {31'b0, e.busy});
      check("u10 Done", {31'b0, done10}, {31'b0, e.done});
    end
  end

  // Scoreboard for the PC_W=4 unit.
  always @(negedge Clk) begin
    if (q4.size() > 0) begin
      exp_t e;
      e = q4.pop_front();
      check("u4 imem_en", {31'b0, bus4.imem_en}, {31'b0, e.en});
      if (e.en) check("u4 imem_addr", {28'b0, bus4.imem_addr}, e.addr);
      check("u4 instr_valid", {31'b0, vld4}, {31'b0, e.vld});
      if (e.vld) begin
        check("u4 pc_out", {28'b0, pc4}, e.pc);
        check("u4 instr", {23'b0, instr4}, {23'b0, e.ins});
      end
      check("u4 opcode", {28'b0, opcode4}, {28'b0, e.opc});
      check("u4 Busy", {31'b0, busy4}, {31'b0, e.busy});
      check("u4 Done", {31'b0, done4}, {31'b0, e.done});
    end
  end

  // Drive one cycle of inputs just after the rising edge.
  task automatic drive(input logic stall, input logic cond, input logic st10, input logic st4);
    @(posedge Clk);
    #1;
    Stall = stall; CondFlag = cond; Start10 = st10; Start4 = st4;
  endtask

  task automatic check_reset10();
    check("u10 rst imem_en", {31'b0, bus10.imem_en}, 0);
    check("u10 rst imem_addr", {22'b0, bus10.imem_addr}, 0);
    check("u10 rst instr_valid", {31'b0, vld10}, 0);
    check("u10 rst pc_out", {22'b0, pc10}, 0);
    check("u10 rst opcode", {28'b0, opcode10}, {28'b0, OP_NOP});
    check("u10 rst Busy", {31'b0, busy10}, 0);
    check("u10 rst Done", {31'b0, done10}, 0);
  endtask

  task automatic check_reset4();
    check("u4 rst imem_en", {31'b0, bus4.imem_en}, 0);
    check("u4 rst imem_addr", {28'b0, bus4.imem_addr}, 0);
    check("u4 rst instr_valid", {31'b0, vld4}, 0);
    check("u4 rst pc_out", {28'b0, pc4}, 0);
    check("u4 rst Busy", {31'b0, busy4}, 0);
    check("u4 rst Done", {31'b0, done4}, 0);
  endtask

  initial begin
    Reset_n = 1'b0; Start10 = 1'b0; Start4 = 1'b0; Stall = 1'b0; CondFlag = 1'b0;
    bus10.imem_data = '0;
    bus4.imem_data  = '0;
    for (int i = 0; i < 1024; i++) rom10[i] = {OP_ADD, 5'd0};
    for (int i = 0; i < 16; i++)   rom4[i]  = {OP_ADD, 5'(i)};
    rom10[0] = {OP_ADD, 5'd1};
    rom10[1] = {OP_MOV, 5'd2};
    rom10[2] = {OP_XOR, 5'd3};
    rom10[3] = {OP_SW,  5'd4};
    rom10[4] = {OP_HALT, 5'd0};
    rom4[15] = {OP_BNE, 5'b00010};

    #3;
    check_reset10();
    check_reset4();
    repeat (2) @(posedge Clk);
    #1 Reset_n = 1'b1;

    // Straight-line program ending in halt.
    drive(0, 0, 1, 0); e10(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0); e10(1, 0, 0, 0, 1, 0);
    for (int n = 0; n < 4; n++) begin
      drive(0, 0, 0, 0); e10(1, n + 1, 1, n, 1, 0);
    end
    drive(0, 0, 0, 0); e10(0, 0, 1, 4, 1, 0);
    drive(0, 0, 0, 0); e10(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0); e10(0, 0, 0, 0, 0, 1);

    // bne at pc 3, offset -2: taken once (one bubble), then not taken.
    rom10[3] = {OP_BNE, 5'b11110};
    drive(0, 0, 1, 0); e10(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0); e10(1, 0, 0, 0, 1, 0);
    for (int n = 0; n < 3; n++) begin
      drive(0, 0, 0, 0); e10(1, n + 1, 1, n, 1, 0);
    end
    drive(0, 1, 0, 0); e10(1, 4, 1, 3, 1, 0);
    drive(0, 0, 0, 0); e10(1, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0); e10(1, 2, 1, 1, 1, 0);
    drive(0, 0, 0, 0); e10(1, 3, 1, 2, 1, 0);
    drive(0, 0, 0, 0); e10(1, 4, 1, 3, 1, 0);
    drive(0, 0, 0, 0); e10(0, 0, 1, 4, 1, 0);
    drive(0, 0, 0, 0); e10(0, 0, 0, 0, 0, 1);

    // Three-cycle stall while pc 2 is presented.
    rom10[3] = {OP_SW, 5'd4};
    drive(0, 0, 1, 0); e10(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0); e10(1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0); e10(1, 1, 1, 0, 1, 0);
    drive(0, 0, 0, 0); e10(1, 2, 1, 1, 1, 0);
    for (int n = 0; n < 3; n++) begin
      drive(1, 0, 0, 0); e10(0, 0, 1, 2, 1, 0);
    end
    drive(0, 0, 0, 0); e10(1, 3, 1, 2, 1, 0);
    drive(0, 0, 0, 0); e10(1, 4, 1, 3, 1, 0);
    drive(0, 0, 0, 0); e10(0, 0, 1, 4, 1, 0);
    drive(0, 0, 0, 0); e10(0, 0, 0, 0, 0, 1);

    // Start ignored while running, then asynchronous reset mid-run.
    drive(0, 0, 1, 0); e10(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0); e10(1, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0); e10(1, 1, 1, 0, 1, 0);
    drive(0, 0, 1, 0); e10(1, 2, 1, 1, 1, 0);
    drive(0, 0, 0, 0); e10(1, 3, 1, 2, 1, 0);
    drive(0, 0, 0, 0);
    #2 Reset_n = 1'b0;
    #1 check_reset10();
    drive(0, 0, 0, 0); Reset_n = 1'b1; e10(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0); e10(0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0); e10(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0); e10(1, 0, 0, 0, 1, 0);
    for (int n = 0; n < 4; n++) begin
      drive(0, 0, 0, 0); e10(1, n + 1, 1, n, 1, 0);
    end
    drive(0, 0, 0, 0); e10(0, 0, 1, 4, 1, 0);
    drive(0, 0, 0, 0); e10(0, 0, 0, 0, 0, 1);

    // PC_W=4: wrap 15 -> 0, then bne at pc 15 (+2) taken -> pc 1.
    drive(0, 0, 0, 1); e4(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0); e4(1, 0, 0, 0, 1, 0);
    for (int n = 0; n < 32; n++) begin
      drive(0, (n == 31), 0, 0); e4(1, (n + 1) % 16, 1, n % 16, 1, 0);
    end
    drive(0, 0, 0, 0); e4(1, 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0); e4(1, 2, 1, 1, 1, 0);
    drive(0, 0, 0, 0); e4(1, 3, 1, 2, 1, 0);
    drive(0, 0, 0, 0);
    #2 Reset_n = 1'b0;
    #1 check_reset4();
    drive(0, 0, 0, 0); Reset_n = 1'b1;
    repeat (2) @(posedge Clk);

    check("scoreboard u10 drained", q10.size(), 0);
    check("scoreboard u4 drained", q4.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
